// File: rtl/distance_meter_blitter.sv
// distance_meter_blitter: walks the five-digit score region and streams one framebuffer write per pixel,
// fetching glyph ink from a 1-cycle-latency sprite ROM or writing background for blank pixels.
module distance_meter_blitter #(
    parameter int UNITS      = 5,
    parameter int WIDTH      = 10,
    parameter int HEIGHT     = 13,
    parameter int DEST_WIDTH = 11,
    parameter int X_POS      = 534,
    parameter int Y_POS      = 5,
    parameter int GLYPH_Y [10] = '{0, 13, 27, 40, 53, 67, 80, 93, 107, 120}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [UNITS-1:0][3:0] digits,
    input  logic                  paint,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            rom_x,
    output logic [7:0]            rom_y,
    input  logic                  rom_data,
    output logic                  fb_valid,
    input  logic                  fb_ready,
    output logic [9:0]            fb_x,
    output logic [7:0]            fb_y,
    output logic                  fb_pixel
);
    localparam int DW = $clog2(UNITS + 1);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(DEST_WIDTH);
    localparam logic [DW-1:0] D_LAST = DW'(UNITS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEST_WIDTH - 1);
    localparam logic [CW-1:0] GAP    = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, WRITE} state_t;

    state_t state, state_n;
    logic [UNITS-1:0][3:0] dig_q;
    logic paint_q;
    logic [DW-1:0] d, d_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [3:0] cur_dig;
    logic last, next_blank, start_blank;

    function automatic logic is_blank(input logic p, input logic [CW-1:0] c, input logic [3:0] v);
        return !p || c == GAP || v > 4'd9;
    endfunction

    function automatic logic [9:0] pix_x(input logic [DW-1:0] dd, input logic [CW-1:0] cc);
        return 10'(X_POS) + 10'(dd) * 10'(DEST_WIDTH) + 10'(cc);
    endfunction

    always_comb begin
        cur_dig     = dig_q[d];
        last        = d == D_LAST && row == R_LAST && col == C_LAST;
        col_n       = col == C_LAST ? '0 : col + 1'b1;
        row_n       = col == C_LAST ? (row == R_LAST ? '0 : row + 1'b1) : row;
        d_n         = col == C_LAST && row == R_LAST ? d + 1'b1 : d;
        next_blank  = is_blank(paint_q, col_n, dig_q[d_n]);
        start_blank = is_blank(paint, '0, digits[0]);
        rom_x       = 4'(col);
        rom_y       = cur_dig > 4'd9 ? 8'd0 : 8'(GLYPH_Y[cur_dig]) + 8'(row);
        state_n     = state;
        case (state)
            IDLE:    state_n = start ? (start_blank ? WRITE : FETCH) : IDLE;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = WRITE;
            WRITE:   state_n = !fb_ready ? WRITE : last ? IDLE : next_blank ? WRITE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            fb_valid <= 1'b0;
            fb_pixel <= 1'b0;
            fb_x     <= '0;
            fb_y     <= '0;
            dig_q    <= '0;
            paint_q  <= 1'b1;
            d        <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dig_q    <= digits;
                    paint_q  <= paint;
                    d        <= '0;
                    row      <= '0;
                    col      <= '0;
                    busy     <= 1'b1;
                    fb_valid <= start_blank;
                    fb_pixel <= 1'b0;
                    fb_x     <= 10'(X_POS);
                    fb_y     <= 8'(Y_POS);
                end
                WAIT: begin
                    fb_valid <= 1'b1;
                    fb_pixel <= rom_data;
                    fb_x     <= pix_x(d, col);
                    fb_y     <= 8'(Y_POS) + 8'(row);
                end
                // Handshake: either finish or step to the next pixel in scan order
                WRITE: if (fb_ready) begin
                    if (last) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fb_valid <= 1'b0;
                    end else begin
                        d        <= d_n;
                        row      <= row_n;
                        col      <= col_n;
                        fb_valid <= next_blank;
                        fb_pixel <= 1'b0;
                        fb_x     <= pix_x(d_n, col_n);
                        fb_y     <= 8'(Y_POS) + 8'(row_n);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_distance_meter_blitter.sv
// tb_distance_meter_blitter: table-driven and randomized redraws checked against a per-pixel image model
// built from the scan-order and blanking rules, with a random sprite ROM of 1-cycle latency.
module tb_distance_meter_blitter;
    logic clk = 0, rst = 1, start = 0, paint = 1, rom_data = 0, fb_ready = 1;
    logic [4:0][3:0] digits = '0;
    logic busy, done, fb_valid, fb_pixel;
    logic [3:0] rom_x;
    logic [7:0] rom_y, fb_y;
    logic [9:0] fb_x;

    distance_meter_blitter dut (
        .clk(clk), .rst(rst), .start(start), .digits(digits), .paint(paint),
        .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y), .rom_data(rom_data),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_x(fb_x), .fb_y(fb_y), .fb_pixel(fb_pixel)
    );

    always #5 clk = ~clk;

    bit rom_mem [16][256];
    always @(posedge clk) rom_data <= rom_mem[rom_x][rom_y];

    int glyph [10] = '{0, 13, 27, 40, 53, 67, 80, 93, 107, 120};

    typedef struct {
        logic [4:0][3:0] dg;
        logic            p;
        bit              rnd_rdy;
        bit              perturb;
        int              exp_busy;
        string           name;
    } vec_t;

    int checks = 0, passed = 0;
    logic [4:0][3:0] exp_dig;
    logic exp_paint;
    bit active = 0, hold_v = 0, after_last = 0;
    int writes, bad, busy_cnt, done_cnt, done_bad, stalls, stab_err;
    logic [9:0] hx;
    logic [7:0] hy;
    logic hp;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    function automatic void exp_write(input int k, output int x, output int y, output logic pix);
        int dd, rr, cc, v;
        dd  = k / 143;
        rr  = (k % 143) / 11;
        cc  = k % 11;
        x   = 534 + dd * 11 + cc;
        y   = 5 + rr;
        v   = int'(exp_dig[dd]);
        pix = (exp_paint && cc != 10 && v <= 9) ? rom_mem[cc][glyph[v] + rr] : 1'b0;
    endfunction

    function automatic int model_busy(input logic [4:0][3:0] dg, input logic p);
        int n = 0;
        for (int k = 0; k < 715; k++) n += (p && k % 11 != 10 && dg[k / 143] <= 9) ? 3 : 1;
        return n;
    endfunction

    always @(negedge clk) if (active) begin
        int x, y;
        logic pix;
        if (after_last && !done) done_bad++;
        after_last = 0;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (busy) done_bad++;
        end
        if (hold_v && (!fb_valid || fb_x != hx || fb_y != hy || fb_pixel != hp)) stab_err++;
        hold_v = fb_valid && !fb_ready;
        hx = fb_x; hy = fb_y; hp = fb_pixel;
        if (fb_valid && !fb_ready) stalls++;
        if (fb_valid && fb_ready) begin
            if (writes < 715) begin
                exp_write(writes, x, y, pix);
                if (int'(fb_x) != x || int'(fb_y) != y || fb_pixel != pix) bad++;
            end else bad++;
            writes++;
            if (writes == 715) after_last = 1;
        end
    end

    task automatic begin_redraw(input logic [4:0][3:0] dg, input logic p);
        @(posedge clk); #1;
        writes = 0; bad = 0; busy_cnt = 0; done_cnt = 0; done_bad = 0; stalls = 0; stab_err = 0;
        hold_v = 0; after_last = 0;
        exp_dig = dg; exp_paint = p;
        digits = dg; paint = p; start = 1; fb_ready = 1; active = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run_redraw(input vec_t v);
        bit got = 0;
        begin_redraw(v.dg, v.p);
        for (int c = 0; c < 20000 && !got; c++) begin
            @(posedge clk); #1;
            fb_ready = v.rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.perturb && (c == 100 || c == 1200)) begin
                digits = 20'($urandom);
                paint = ~v.p;
                start = 1;
            end else start = 0;
            got = done_cnt > 0;
        end
        start = 0; fb_ready = 1;
        repeat (5) @(posedge clk);
        #1 active = 0;
        check({v.name, " done_seen"}, int'(got), 1);
        check({v.name, " writes"}, writes, 715);
        check({v.name, " image_mismatches"}, bad, 0);
        check({v.name, " busy_cycles"}, busy_cnt - stalls, v.exp_busy);
        check({v.name, " done_pulses"}, done_cnt, 1);
        check({v.name, " done_timing_errors"}, done_bad, 0);
        check({v.name, " hold_stability_errors"}, stab_err, 0);
    endtask

    vec_t vecs [6];

    initial begin
        vec_t r;
        for (int x = 0; x < 16; x++) for (int y = 0; y < 256; y++) rom_mem[x][y] = 1'($urandom);
        vecs[0] = '{{4'd3, 4'd2, 4'd1, 4'd0, 4'd0}, 1'b1, 1'b0, 1'b0, 2015, "paint_00123"};
        vecs[1] = '{{4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, 1'b0, 1'b0, 1'b0, 715,  "blank_99999"};
        vecs[2] = '{{4'd3, 4'd2, 4'd1, 4'd0, 4'd0}, 1'b1, 1'b1, 1'b0, 2015, "backpressure_00123"};
        vecs[3] = '{{4'd5, 4'd6, 4'd7, 4'd8, 4'd9}, 1'b1, 1'b0, 1'b1, 2015, "perturb_98765"};
        vecs[4] = '{{4'd5, 4'd4, 4'd12, 4'd2, 4'd1}, 1'b1, 1'b0, 1'b0, 1755, "invalid_pos2"};
        vecs[5] = '{{4'd15, 4'd13, 4'd12, 4'd11, 4'd10}, 1'b1, 1'b1, 1'b0, 715, "all_invalid"};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset fb_valid", int'(fb_valid), 0);
        check("reset fb_pixel", int'(fb_pixel), 0);
        check("reset fb_x", int'(fb_x), 0);
        check("reset fb_y", int'(fb_y), 0);
        check("reset rom_xy", int'({rom_x, rom_y}), 0);

        foreach (vecs[i]) run_redraw(vecs[i]);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 5; i++) r.dg[i] = 4'($urandom_range(0, 11));
            r.p = $urandom_range(0, 3) != 0;
            r.rnd_rdy = 1'($urandom_range(0, 1));
            r.perturb = 0;
            r.exp_busy = model_busy(r.dg, r.p);
            r.name = $sformatf("random%0d", n);
            run_redraw(r);
        end

        begin_redraw({4'd4, 4'd3, 4'd2, 4'd1, 4'd7}, 1'b1);
        for (int c = 0; c < 5000 && writes < 300; c++) begin
            @(posedge clk); #1;
            fb_ready = 1'($urandom_range(0, 1));
        end
        check("abort writes_before_reset", int'(writes >= 300), 1);
        check("abort image_mismatches", bad, 0);
        active = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        fb_ready = 1;
        check("abort fb_valid", int'(fb_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        done_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || fb_valid) done_cnt++;
        end
        check("abort quiet_after_reset", done_cnt, 0);
        r = '{{4'd4, 4'd3, 4'd2, 4'd1, 4'd7}, 1'b1, 1'b0, 1'b0, 2015, "after_abort"};
        run_redraw(r);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
